// File: rtl/peripheral_wb_slave_mem_if.sv
// Wishbone B3 signal bundle between a bus master and the slave memory.
// Latency: none; this is wiring only.
// Backpressure: carried by ack/err/rty from the slave; rty is unused by the memory.
interface peripheral_wb_slave_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/peripheral_wb_slave_mem.sv
// Wishbone B3 slave memory: classic cycles, wait states, CTI/BTE registered-feedback bursts, error on out-of-range.
// Latency: first ack WAIT_STATES+1 cycles after the strobe is sampled; burst beats then ack every cycle.
// Backpressure: the master is held only by wait states; cyc/stb low ends the cycle and discards any pending write.
module peripheral_wb_slave_mem #(
  parameter int            AW          = 32,
  parameter int            DW          = 32,
  parameter int            MEM_WORDS   = 256,
  parameter logic [AW-1:0] BASE_ADDR   = '0,
  parameter int            WAIT_STATES = 0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  peripheral_wb_slave_mem_if.slave bus
);

  localparam int NB   = DW / 8;
  localparam int LB   = $clog2(NB);
  localparam int IW   = $clog2(MEM_WORDS);
  localparam int SPAN = MEM_WORDS * NB;

  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_BURST,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] badr_q, badr_d;
  logic          mem_we;
  logic          cyc_stb;
  logic          burst_req;
  logic [AW-1:0] beat_adr;
  logic [AW-1:0] nxt_adr;

  logic [DW-1:0] mem [MEM_WORDS];

  // Upper bound is computed one bit wider so a window touching the top of the address space cannot wrap.
  function automatic logic in_range(input logic [AW-1:0] a);
    logic [AW:0] lo;
    logic [AW:0] hi;
    logic [AW:0] x;
    lo = {1'b0, BASE_ADDR};
    hi = lo + (AW+1)'(SPAN);
    x  = {1'b0, a};
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
    return IW'((a - BASE_ADDR) >> LB);
  endfunction

  // Wrapping bursts only carry into the low bits covering k beats; the block base stays fixed.
  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [2:0] cti,
                                             input logic [1:0] bte);
    logic [AW-1:0] mask;
    logic [AW-1:0] inc;
    inc = a + AW'(NB);
    unique case (bte)
      2'b01:   mask = AW'(4 * NB - 1);
      2'b10:   mask = AW'(8 * NB - 1);
      2'b11:   mask = AW'(16 * NB - 1);
      default: mask = '1;
    endcase
    if (cti == CTI_CONST) return a;
    return (a & ~mask) | (inc & mask);
  endfunction

  // Next-state and next-output decode for the bus FSM.
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    badr_d    = badr_q;
    mem_we    = 1'b0;
    cyc_stb   = bus.wb_cyc_i && bus.wb_stb_i;
    burst_req = (bus.wb_cti_i == CTI_CONST) || (bus.wb_cti_i == CTI_INCR);
    beat_adr  = (state_q == S_BURST) ? badr_q : bus.wb_adr_i;
    nxt_adr   = next_adr(beat_adr, bus.wb_cti_i, bus.wb_bte_i);

    unique case (state_q)
      S_IDLE: begin
        if (cyc_stb && !ack_q && !err_q) begin
          if (!in_range(bus.wb_adr_i)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            dat_d   = mem[word_idx(bus.wb_adr_i)];
          end
        end
      end
      S_WAIT: begin
        if (!bus.wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          dat_d   = mem[word_idx(bus.wb_adr_i)];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK, S_BURST: begin
        // A beat closes on this edge; continue the burst only while the master keeps requesting it.
        state_d = S_IDLE;
        if (cyc_stb) begin
          mem_we = bus.wb_we_i && in_range(bus.wb_adr_i);
          if (burst_req) begin
            if (in_range(nxt_adr)) begin
              state_d = S_BURST;
              ack_d   = 1'b1;
              badr_d  = nxt_adr;
              dat_d   = mem[word_idx(nxt_adr)];
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered bus outputs; ack/err come straight from flops.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      cnt_q   <= '0;
      badr_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      badr_q  <= badr_d;
    end
  end

  // RAM byte-lane writes, always at the master's address; suppressed on a reset edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_ni && mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wb_sel_i[b]) begin
          mem[word_idx(bus.wb_adr_i)][b*8 +: 8] <= bus.wb_dat_i[b*8 +: 8];
        end
      end
    end
  end

  assign bus.wb_dat_o = dat_q;
  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;
  assign bus.wb_rty_o = 1'b0;

endmodule

// File: tb/tb_peripheral_wb_slave_mem.sv
module tb_peripheral_wb_slave_mem;

  localparam int          MEM_WORDS = 256;
  localparam logic [31:0] LIMIT     = 32'd1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        dut_sel;
  logic        ack_s, err_s;
  logic [31:0] dat_s;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [MEM_WORDS];

  peripheral_wb_slave_mem_if #(.AW(32), .DW(32)) bus0 ();
  peripheral_wb_slave_mem_if #(.AW(32), .DW(32)) bus1 ();

  assign bus0.wb_adr_i = adr;
  assign bus0.wb_dat_i = wdat;
  assign bus0.wb_sel_i = sel;
  assign bus0.wb_we_i  = we;
  assign bus0.wb_cyc_i = cyc & ~dut_sel;
  assign bus0.wb_stb_i = stb & ~dut_sel;
  assign bus0.wb_cti_i = cti;
  assign bus0.wb_bte_i = bte;
  assign bus1.wb_adr_i = adr;
  assign bus1.wb_dat_i = wdat;
  assign bus1.wb_sel_i = sel;
  assign bus1.wb_we_i  = we;
  assign bus1.wb_cyc_i = cyc & dut_sel;
  assign bus1.wb_stb_i = stb & dut_sel;
  assign bus1.wb_cti_i = cti;
  assign bus1.wb_bte_i = bte;

  assign ack_s = dut_sel ? bus1.wb_ack_o : bus0.wb_ack_o;
  assign err_s = dut_sel ? bus1.wb_err_o : bus0.wb_err_o;
  assign dat_s = dut_sel ? bus1.wb_dat_o : bus0.wb_dat_o;

  peripheral_wb_slave_mem #(.AW(32), .DW(32), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(32'h0),
                            .WAIT_STATES(0)) u_dut0 (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus0)
  );

  peripheral_wb_slave_mem #(.AW(32), .DW(32), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(32'h0),
                            .WAIT_STATES(3)) u_dut1 (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (bus1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return a < LIMIT;
  endfunction

  // Reference next-beat address: wrap within an aligned block of k words.
  function automatic logic [31:0] ref_next(input logic [31:0] a, input logic [2:0] c, input logic [1:0] b);
    logic [31:0] blk;
    if (c == 3'b001) return a;
    if (b == 2'b00) return a + 32'd4;
    case (b)
      2'b01:   blk = 32'd16;
      2'b10:   blk = 32'd32;
      default: blk = 32'd64;
    endcase
    return (a / blk) * blk + ((a % blk) + 32'd4) % blk;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic wb_classic(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output logic ga, output logic ge,
                            output int lat, output logic tail);
    @(posedge clk); #1;
    adr = a; wdat = d; sel = s; we = w; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    while (!(ack_s || err_s) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    ga = ack_s; ge = err_s; rd = dat_s;
    @(posedge clk); #1;
    tail = ack_s | err_s;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic classic_op(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int exp_lat, output logic [31:0] rd);
    logic ga, ge, tl, inr;
    int   lat;
    wb_classic(w, a, d, s, rd, ga, ge, lat, tl);
    inr = in_rng(a);
    check_eq({tag, "/ack"}, 32'(ga), 32'(inr));
    check_eq({tag, "/err"}, 32'(ge), 32'(!inr));
    check_eq({tag, "/lat"}, lat, inr ? exp_lat : 1);
    check_eq({tag, "/tail"}, 32'(tl), 32'd0);
    if (!dut_sel && w && ga) ref_write(a, d, s);
    if (!dut_sel && !w && inr) check_eq({tag, "/dat"}, rd, ref_mem[a[9:2]]);
  endtask

  task automatic wb_burst(input string tag, input logic w, input logic [31:0] a, input int n,
                          input logic [2:0] kind, input logic [1:0] b, input int rst_beat);
    logic [31:0] cur;
    logic        hit;
    int          lat;
    cur = a;
    hit = 1'b1;
    @(posedge clk); #1;
    adr = cur; wdat = $urandom(); sel = 4'hF; we = w; bte = b;
    cti = (n == 1) ? 3'b111 : kind; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    while (!(ack_s || err_s) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "/lat"}, lat, 1);
    for (int i = 0; i < n; i++) begin
      hit = in_rng(cur);
      check_eq({tag, "/ack"}, 32'(ack_s), 32'(hit));
      check_eq({tag, "/err"}, 32'(err_s), 32'(!hit));
      if (!hit) break;
      if (!w) check_eq({tag, "/dat"}, dat_s, ref_mem[cur[9:2]]);
      if (i == rst_beat) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "/rst_ack"}, 32'(ack_s), 32'd0);
        check_eq({tag, "/rst_err"}, 32'(err_s), 32'd0);
        check_eq({tag, "/rst_dat"}, dat_s, 32'd0);
        rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        return;
      end
      @(posedge clk); #1;
      if (w) ref_write(cur, wdat, 4'hF);
      if (i < n - 1) begin
        cur  = ref_next(cur, kind, b);
        adr  = cur;
        wdat = $urandom();
        cti  = (i + 1 == n - 1) ? 3'b111 : kind;
      end
    end
    if (!hit) begin
      @(posedge clk); #1;
    end
    check_eq({tag, "/tail_ack"}, 32'(ack_s), 32'd0);
    check_eq({tag, "/tail_err"}, 32'(err_s), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, got timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] ra;
    int          op;
    rst_n = 1'b0; adr = '0; wdat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    cti = 3'b000; bte = 2'b00; dut_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst/ack0", 32'(bus0.wb_ack_o), 32'd0);
    check_eq("rst/err0", 32'(bus0.wb_err_o), 32'd0);
    check_eq("rst/rty0", 32'(bus0.wb_rty_o), 32'd0);
    check_eq("rst/dat0", bus0.wb_dat_o, 32'd0);
    check_eq("rst/ack1", 32'(bus1.wb_ack_o), 32'd0);
    check_eq("rst/err1", 32'(bus1.wb_err_o), 32'd0);
    check_eq("rst/dat1", bus1.wb_dat_o, 32'd0);
    rst_n = 1'b1;

    // Preload every word so the reference model is fully known.
    wb_burst("fill", 1'b1, 32'h0, MEM_WORDS, 3'b010, 2'b00, -1);

    classic_op("t1w", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, rd);
    classic_op("t1r", 1'b0, 32'h10, 32'h0, 4'hF, 1, rd);
    check_eq("t1/dat", rd, 32'hDEADBEEF);
    classic_op("t2w", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 1, rd);
    classic_op("t2r", 1'b0, 32'h10, 32'h0, 4'hF, 1, rd);
    check_eq("t2/dat", rd, 32'hDEADBEAA);

    dut_sel = 1'b1;
    classic_op("t3w", 1'b1, 32'h40, 32'h12345678, 4'hF, 4, rd);
    classic_op("t3r", 1'b0, 32'h40, 32'h0, 4'hF, 4, rd);
    check_eq("t3/dat", rd, 32'h12345678);
    dut_sel = 1'b0;

    wb_burst("t4w", 1'b1, 32'h20, 8, 3'b010, 2'b00, -1);
    wb_burst("t4r", 1'b0, 32'h20, 8, 3'b010, 2'b00, -1);
    wb_burst("t5", 1'b0, 32'h28, 4, 3'b010, 2'b01, -1);
    classic_op("t6", 1'b0, LIMIT, 32'h0, 4'hF, 1, rd);
    wb_burst("ovr", 1'b0, 32'h3F8, 4, 3'b010, 2'b00, -1);

    wb_burst("rstb", 1'b1, 32'h80, 8, 3'b010, 2'b00, 2);
    for (int i = 0; i < 4; i++) classic_op("rstrd", 1'b0, 32'h80 + 32'(4 * i), 32'h0, 4'hF, 1, rd);

    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 3);
      ra = 32'($urandom_range(0, 319)) << 2;
      case (op)
        0: classic_op("rnd_w", 1'b1, ra, $urandom(), 4'($urandom_range(1, 15)), 1, rd);
        1: classic_op("rnd_r", 1'b0, ra, 32'h0, 4'hF, 1, rd);
        2: wb_burst("rnd_br", 1'b0, ra, $urandom_range(1, 16),
                    ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010, 2'($urandom_range(0, 3)), -1);
        default: wb_burst("rnd_bw", 1'b1, ra, $urandom_range(1, 16), 3'b010,
                          2'($urandom_range(0, 3)), -1);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
